pixel_clip_queue: RTL and testbench
===================================

// Module: pixel_clip_queue
// PURPOSE
//  - Sits directly downstream of the triangle/circle drawing FSMs (vga_x/vga_y/vga_colour/vga_plot)
//    and upstream of the framebuffer write port.
//  - Discards off-screen pixels, buffers on-screen pixels in a FIFO and drains them
//    under a valid/ready handshake.
//  - Counts clipped and overflow-dropped pixels so the verif bench can score them.
// PARAMETERS
//  SCREEN_W  160  visible columns; x >= SCREEN_W is clipped
//  SCREEN_H  120  visible rows; y >= SCREEN_H is clipped
//  DEPTH     16   FIFO entries; power of two, >= 2
//  CNT_W     16   width of clip_count / drop_count
// PORTS
//  clk         in   1              single clock domain
//  rst         in   1              synchronous, active-high reset
//  in_x        in   8              pixel column from drawer
//  in_y        in   7              pixel row from drawer
//  in_colour   in   3              pixel colour from drawer
//  in_plot     in   1              pixel valid; no backpressure to drawer
//  flush       in   1              synchronous FIFO clear (e.g. on new start)
//  out_x       out  8              head-of-queue column
//  out_y       out  7              head-of-queue row
//  out_colour  out  3              head-of-queue colour
//  out_plot    out  1              head valid (== !empty)
//  out_ready   in   1              framebuffer accepts head this cycle
//  level       out  $clog2(DEPTH)+1  current occupancy
//  full        out  1              level == DEPTH
//  clip_count  out  CNT_W          pixels discarded as off-screen; saturating
//  drop_count  out  CNT_W          on-screen pixels lost to overflow; saturating
// BEHAVIOUR
//  - Reset (rst=1 at posedge): level=0, full=0, out_plot=0, out_x/out_y/out_colour=0,
//    clip_count=0, drop_count=0. Any in-flight pixel in that cycle is discarded and not counted.
//  - Clip: when in_plot=1 and (in_x>=SCREEN_W or in_y>=SCREEN_H), the pixel is not stored.
//    clip_count increments by 1 and saturates at all-ones.
//  - Pop: fires when out_plot && out_ready. The head advances at the next posedge.
//  - Push: fires when in_plot=1, the pixel is on-screen, and (level<DEPTH or pop this cycle).
//    Push and pop in the same cycle leave level unchanged, including when full.
//  - Drop: an on-screen pixel with level==DEPTH and no pop is not stored.
//    drop_count increments by 1 and saturates; FIFO contents are unchanged.
//  - Ordering: strict FIFO order, no reordering and no merging of duplicate coordinates.
//  - Latency: a pixel pushed at edge N into an empty queue appears with out_plot=1 after edge N.
//    This is 1-cycle fall-through; no combinational path from in_* to out_*.
//  - Stability: while out_plot=1 and out_ready=0, out_x/out_y/out_colour hold constant.
//  - out_* when out_plot=0: hold the last popped value (0 after reset); consumers must ignore them.
//  - Flush: flush=1 empties the FIFO at the next edge (level=0, out_plot=0).
//    Flush beats push and pop in the same cycle; counters are NOT cleared by flush.
//  - Pointer wrap: pointers are $clog2(DEPTH)+1 bits. full/empty come from MSB-differing
//    equality; wrap past DEPTH-1 is seamless.
//  - Counters: clip and drop are mutually exclusive per cycle; each increments by at most 1 per cycle.
// TESTING
//  1. Reset mid-stream: 5 pixels queued, rst=1 for 1 cycle
//     -> level=0, out_plot=0, both counts=0 on the next cycle.
//  2. Clip boundaries: push (159,119),(160,0),(0,120),(255,127)
//     -> only (159,119) emerges; clip_count=3.
//  3. Overflow: out_ready=0, push 20 on-screen pixels (DEPTH=16)
//     -> level=16, full=1, drop_count=4; drain order equals the first 16 pushed.
//  4. Full + simultaneous push/pop: queue full, out_ready=1 and in_plot=1 for 10 cycles
//     -> level stays 16, drop_count unchanged, 10 pixels out in order.
//  5. Flush vs push: flush=1 and in_plot=1 on the same cycle with 7 queued
//     -> level=0 next cycle, clip/drop counts unchanged.
//  6. Drawer stream: triangle FSM (centre 80,60, diam 80) feeds the queue with random out_ready
//     -> framebuffer image matches the direct-write reference image; drop_count=0 when ready>=50%.

Source files
------------

// File: rtl/pixel_clip_queue.sv
// pixel_clip_queue
//   Sits between the triangle/circle drawers and the framebuffer write port.
//   Pixels outside the visible window are discarded and counted. On-screen
//   pixels are queued in a DEPTH-entry FIFO and drained with a valid/ready
//   handshake. On-screen pixels that arrive while the queue is full and not
//   popping are dropped and counted.
//
// Ports
//   clk_i, rst_i          single clock, synchronous active-high reset
//   in_x_i/in_y_i/in_colour_i, in_plot_i
//                         pixel from the drawer; no backpressure
//   flush_i               empties the queue at the next edge (counters kept)
//   out_x_o/out_y_o/out_colour_o, out_plot_o, out_ready_i
//                         head of queue, valid/ready to the framebuffer
//   level_o, full_o       occupancy, level_o == DEPTH
//   clip_count_o          off-screen pixels discarded (saturating)
//   drop_count_o          on-screen pixels lost to overflow (saturating)
module pixel_clip_queue #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DEPTH    = 16,   // power of two, >= 2
  parameter int CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [7:0]               in_x_i,
  input  logic [6:0]               in_y_i,
  input  logic [2:0]               in_colour_i,
  input  logic                     in_plot_i,
  input  logic                     flush_i,
  output logic [7:0]               out_x_o,
  output logic [6:0]               out_y_o,
  output logic [2:0]               out_colour_o,
  output logic                     out_plot_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic [CNT_W-1:0]         clip_count_o,
  output logic [CNT_W-1:0]         drop_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_t;

  // Storage and state
  pix_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  pix_t             last_q, last_d;   // last popped pixel, shown while empty
  logic [CNT_W-1:0] clip_q, clip_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  // Per-cycle decisions
  pix_t in_pix, head;
  logic empty, full, on_screen;
  logic pop, push, clip, drop;

  assign in_pix = '{x: in_x_i, y: in_y_i, colour: in_colour_i};
  assign head   = mem_q[rd_q[AW-1:0]];

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign on_screen = (int'(in_x_i) < SCREEN_W) && (int'(in_y_i) < SCREEN_H);

  // Flush overrides both sides of the FIFO. A full queue still accepts a
  // push when the head leaves in the same cycle.
  assign pop  = !empty && out_ready_i && !flush_i;
  assign push = in_plot_i && on_screen && (!full || pop) && !flush_i;
  assign clip = in_plot_i && !on_screen;
  assign drop = in_plot_i && on_screen && full && !pop && !flush_i;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    last_d = last_q;
    clip_d = clip_q;
    drop_d = drop_q;

    if (flush_i) begin
      // Catch the read pointer up to the write pointer: queue reads empty.
      rd_d = wr_q;
    end else begin
      if (pop) begin
        rd_d   = rd_q + PW'(1);
        last_d = head;
      end
      if (push) wr_d = wr_q + PW'(1);
    end

    if (clip && (clip_q != '1)) clip_d = clip_q + CNT_W'(1);
    if (drop && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      last_q <= '0;
      clip_q <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      last_q <= last_d;
      clip_q <= clip_d;
      drop_q <= drop_d;
    end
  end

  // Payload storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_q[AW-1:0]] <= in_pix;
  end

  // Head is read straight from storage, so a pixel written at one edge is
  // visible right after it, with no path from in_* to out_*.
  pix_t out_pix;
  assign out_pix      = empty ? last_q : head;
  assign out_x_o      = out_pix.x;
  assign out_y_o      = out_pix.y;
  assign out_colour_o = out_pix.colour;
  assign out_plot_o   = !empty;

  assign level_o      = wr_q - rd_q;
  assign full_o       = full;
  assign clip_count_o = clip_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_pixel_clip_queue.sv
module tb_pixel_clip_queue;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] in_x_i;
  logic [6:0] in_y_i;
  logic [2:0] in_colour_i;
  logic       in_plot_i;
  logic       flush_i;
  logic [7:0] out_x_o;
  logic [6:0] out_y_o;
  logic [2:0] out_colour_o;
  logic       out_plot_o;
  logic       out_ready_i;
  logic [4:0] level_o;
  logic       full_o;
  logic [15:0] clip_count_o;
  logic [15:0] drop_count_o;

  pixel_clip_queue #(.SCREEN_W(SW), .SCREEN_H(SH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_x_i(in_x_i), .in_y_i(in_y_i), .in_colour_i(in_colour_i), .in_plot_i(in_plot_i),
    .flush_i(flush_i),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_colour_o(out_colour_o),
    .out_plot_o(out_plot_o), .out_ready_i(out_ready_i),
    .level_o(level_o), .full_o(full_o),
    .clip_count_o(clip_count_o), .drop_count_o(drop_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Scoreboard / model state
  pix_t sb[$];
  pix_t last_pop;
  int   e_clip, e_drop;
  logic [2:0] fb  [SW*SH];
  logic [2:0] ref_img [SW*SH];
  pix_t pixq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs against the model (outputs depend only on
  // state), drive this cycle's inputs, then advance the model.
  task automatic cyc(input bit plot, input int x, input int y, input int c,
                     input bit rdy, input bit fl, input bit rs);
    pix_t head, p;
    bit exp_plot, pop, onscr, acc;
    @(negedge clk);
    exp_plot = (sb.size() != 0);
    head = exp_plot ? sb[0] : last_pop;
    chk("out_plot", 32'(out_plot_o), 32'(exp_plot));
    chk("level", 32'(level_o), 32'(sb.size()));
    chk("full", 32'(full_o), 32'(sb.size() == DEPTH));
    chk("head", 32'({out_x_o, out_y_o, out_colour_o}), 32'(head));
    chk("clip_count", 32'(clip_count_o), 32'(e_clip));
    chk("drop_count", 32'(drop_count_o), 32'(e_drop));

    p = '{x: 8'(x), y: 7'(y), c: 3'(c)};
    rst_i = rs; in_plot_i = plot; in_x_i = p.x; in_y_i = p.y; in_colour_i = p.c;
    out_ready_i = rdy; flush_i = fl;

    if (rs) begin
      sb.delete(); last_pop = '0; e_clip = 0; e_drop = 0;
    end else begin
      onscr = (x < SW) && (y < SH);
      if (plot && !onscr && e_clip != 16'hffff) e_clip++;
      if (fl) begin
        sb.delete();
      end else begin
        pop = exp_plot && rdy;
        acc = plot && onscr && (sb.size() < DEPTH || pop);
        if (plot && onscr && !acc && e_drop != 16'hffff) e_drop++;
        if (pop) begin
          last_pop = sb.pop_front();
          fb[int'(last_pop.y) * SW + int'(last_pop.x)] = last_pop.c;
        end
        if (acc) sb.push_back(p);
      end
    end
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 0, rdy, 0, 0);
  endtask

  // Drain with out_ready high; bounded so a stuck DUT still ends the run.
  task automatic drain();
    for (int i = 0; i < 64 && sb.size() != 0; i++) idle(1);
    idle(1);
    chk("drain_empty", 32'(level_o), 32'd0);
  endtask

  task automatic line(input int x0, input int y0, input int x1, input int y1, input int c);
    int dx, dy, sx, sy, err, e2, x, y;
    pix_t p;
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy; x = x0; y = y0;
    for (int k = 0; k < 1000; k++) begin
      p = '{x: 8'(x), y: 7'(y), c: 3'(c)};
      pixq.push_back(p);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  initial begin
    int diffs;
    pix_t p;
    last_pop = '0; e_clip = 0; e_drop = 0;
    rst_i = 1; in_plot_i = 0; in_x_i = 0; in_y_i = 0; in_colour_i = 0;
    flush_i = 0; out_ready_i = 0;
    repeat (2) @(posedge clk);

    // Test 1: reset mid-stream
    cyc(1, 200, 5, 1, 0, 0, 0);                  // clipped, counter nonzero
    for (int i = 0; i < 5; i++) cyc(1, 10 + i, 20 + i, i, 0, 0, 0);
    cyc(1, 50, 50, 7, 0, 0, 1);                  // rst with an in-flight pixel
    idle(0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_plot", 32'(out_plot_o), 32'd0);
    chk("rst_clip", 32'(clip_count_o), 32'd0);
    chk("rst_drop", 32'(drop_count_o), 32'd0);
    chk("rst_out", 32'({out_x_o, out_y_o, out_colour_o}), 32'd0);

    // Test 2: clip boundaries
    cyc(1, 159, 119, 5, 0, 0, 0);
    cyc(1, 160, 0, 1, 0, 0, 0);
    cyc(1, 0, 120, 2, 0, 0, 0);
    cyc(1, 255, 127, 3, 0, 0, 0);
    idle(0);
    chk("clip3_level", 32'(level_o), 32'd1);
    chk("clip3_head", 32'({out_x_o, out_y_o}), 32'({8'd159, 7'd119}));
    chk("clip3_count", 32'(clip_count_o), 32'd3);
    drain();

    // Test 3: overflow with out_ready low
    for (int i = 0; i < 20; i++) cyc(1, i * 7, i * 5, i, 0, 0, 0);
    idle(0);
    chk("ovf_level", 32'(level_o), 32'd16);
    chk("ovf_full", 32'(full_o), 32'd1);
    chk("ovf_drop", 32'(drop_count_o), 32'd4);

    // Test 4: full with simultaneous push/pop
    for (int i = 0; i < 10; i++) cyc(1, 100 + i, 100 + i, i, 1, 0, 0);
    idle(0);
    chk("pp_level", 32'(level_o), 32'd16);
    chk("pp_drop", 32'(drop_count_o), 32'd4);
    drain();

    // Test 5: flush beats push
    for (int i = 0; i < 7; i++) cyc(1, 30 + i, 40, i, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1, 0);
    idle(0);
    chk("flush_level", 32'(level_o), 32'd0);
    chk("flush_plot", 32'(out_plot_o), 32'd0);
    chk("flush_clip", 32'(clip_count_o), 32'd3);
    chk("flush_drop", 32'(drop_count_o), 32'd4);
    // Flushed pixel must not reappear and the queue must still work after.
    cyc(1, 9, 9, 6, 0, 0, 0);
    drain();

    // Test 6: triangle outline stream with random readiness
    for (int i = 0; i < SW * SH; i++) begin fb[i] = '0; ref_img[i] = '0; end
    line(80, 20, 45, 80, 1);
    line(45, 80, 115, 80, 2);
    line(115, 80, 80, 20, 4);
    foreach (pixq[i]) ref_img[int'(pixq[i].y) * SW + int'(pixq[i].x)] = pixq[i].c;
    begin
      int d0;
      d0 = e_drop;
      while (pixq.size() != 0) begin
        if ($urandom_range(1, 0) == 1) begin
          p = pixq.pop_front();
          cyc(1, int'(p.x), int'(p.y), int'(p.c), $urandom_range(3, 0) != 0, 0, 0);
        end else begin
          idle($urandom_range(3, 0) != 0);
        end
      end
      drain();
      chk("tri_drop", 32'(drop_count_o), 32'(d0));
    end
    diffs = 0;
    for (int i = 0; i < SW * SH; i++) if (fb[i] !== ref_img[i]) diffs++;
    chk("tri_image", 32'(diffs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
